// File: rtl/oled_fb_reader_if.sv
// Pixel write stream into the OLED framebuffer.
// Writer drives data/valid/sof; the framebuffer returns ready and its write pointer.
interface oled_fb_reader_if #(
  parameter int AW = 15
);
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_sof;
  logic [AW-1:0] wr_addr;

  modport master (
    output wr_data,
    output wr_valid,
    output wr_sof,
    input  wr_ready,
    input  wr_addr
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    input  wr_sof,
    output wr_ready,
    output wr_addr
  );
endinterface

// File: rtl/oled_fb_reader.sv
// RGB332 framebuffer feeding the ST7789 scan core with registered RGB565 pixels.
// Falls back to an 8-bar colour test pattern when fb_enable is low.
module oled_fb_reader #(
  parameter int C_x_size = 128,
  parameter int C_y_size = 160,
  parameter int C_x_bits = 7,
  parameter int C_y_bits = 8,
  parameter int C_depth  = C_x_size * C_y_size
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [C_x_bits-1:0] x,
  input  logic [C_y_bits-1:0] y,
  input  logic                next_pixel,
  input  logic                fb_enable,
  output logic [15:0]         color,
  output logic                frame_start,
  oled_fb_reader_if.slave     wr
);

  localparam int AW = C_x_bits + C_y_bits;

  typedef struct packed {
    logic                en;
    logic                oor;
    logic [C_x_bits-1:0] x;
  } s1_t;

  logic [7:0]    mem [C_depth];
  logic [7:0]    rd_q;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_tgt;
  logic [AW-1:0] wr_nxt;
  logic          wr_fire;
  logic          rdy_q;
  logic [AW-1:0] wptr_q;
  logic          oor;
  logic          s1_valid;
  s1_t           s1;
  logic [15:0]   color_d;

  function automatic logic [15:0] expand(
    input logic [7:0] d
  );
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = d[7:5];
    g = d[4:2];
    b = d[1:0];
    return {r, r[2:1], g, g, b, b, b[1]};
  endfunction

  function automatic logic [15:0] bar(
    input logic [2:0] idx
  );
    logic [15:0] c;
    unique case (idx)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      3'd7: c = 16'h0000;
    endcase
    return c;
  endfunction

  assign wr.wr_ready = rdy_q;
  assign wr.wr_addr  = wptr_q;
  assign wr_fire     = wr.wr_valid && rdy_q;
  assign wr_tgt      = wr.wr_sof ? '0 : wptr_q;
  assign wr_nxt      = (wr_tgt == AW'(C_depth - 1))
                     ? '0 : wr_tgt + 1'b1;

  // Rows past the panel never touch the RAM; address 0 keeps the index legal.
  assign oor     = y >= C_y_bits'(C_y_size);
  assign rd_addr = oor ? '0 : {y, x};

  // No reset on the array so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_tgt] <= wr.wr_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q  <= 1'b0;
      wptr_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (wr_fire)
        wptr_q <= wr_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid    <= 1'b0;
      s1          <= '0;
      frame_start <= 1'b0;
    end else begin
      s1_valid    <= next_pixel;
      frame_start <= next_pixel && x == '0 && y == '0;
      if (next_pixel)
        s1 <= '{en: fb_enable, oor: oor, x: x};
    end
  end

  always_comb begin
    color_d = 16'h0000;
    unique case (1'b1)
      s1.oor:           color_d = 16'h0000;
      !s1.oor && s1.en: color_d = expand(rd_q);
      default:          color_d = bar(s1.x[C_x_bits-1 -: 3]);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      color <= 16'h0000;
    else if (s1_valid)
      color <= color_d;
  end

endmodule

// File: tb/tb_oled_fb_reader.sv
// Randomised bench for oled_fb_reader against a byte-array framebuffer model.
// Colours are derived arithmetically from the RGB332 fields and a bar table.
module tb_oled_fb_reader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  x = '0;
  logic [7:0]  y = '0;
  logic        next_pixel = 1'b0;
  logic        fb_enable = 1'b0;
  logic [15:0] color;
  logic        frame_start;

  oled_fb_reader_if wif ();

  oled_fb_reader dut (
    .clk         (clk),
    .resetn      (resetn),
    .x           (x),
    .y           (y),
    .next_pixel  (next_pixel),
    .fb_enable   (fb_enable),
    .color       (color),
    .frame_start (frame_start),
    .wr          (wif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  ref_mem [20480];
  int          mdl_addr = 0;
  logic [15:0] bar_tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rgb(input logic [7:0] d);
    int r, g, b;
    r = int'(d) / 32;
    g = (int'(d) / 4) % 8;
    b = int'(d) % 4;
    return 16'((r * 4 + r / 2) * 2048 + (g * 9) * 32 + (b * 10 + b / 2));
  endfunction

  function automatic logic [15:0] exp_color(input int xi, input int yi,
                                            input bit en);
    if (yi >= 160) return 16'h0000;
    if (en) return rgb(ref_mem[yi * 128 + xi]);
    return bar_tbl[xi / 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cycle(input bit v, input bit s, input logic [7:0] d);
    int tgt;
    wif.wr_valid = v;
    wif.wr_sof   = s;
    wif.wr_data  = d;
    tick();
    if (v) begin
      tgt = s ? 0 : mdl_addr;
      ref_mem[tgt] = d;
      mdl_addr = (tgt + 1) % 20480;
    end
    wif.wr_valid = 1'b0;
    wif.wr_sof   = 1'b0;
  endtask

  task automatic request(input int xi, input int yi, input bit en,
                         input int gap);
    logic [15:0] e;
    x = 7'(xi);
    y = 8'(yi);
    fb_enable = en;
    next_pixel = 1'b1;
    e = exp_color(xi, yi, en);
    tick();
    next_pixel = 1'b0;
    chk("frame_start_t1", frame_start, (xi == 0 && yi == 0));
    tick();
    chk("color_t2", color, e);
    chk("frame_start_t2", frame_start, 1'b0);
    for (int i = 0; i < gap; i++) begin
      fb_enable = 1'($urandom);
      tick();
    end
    chk("color_held", color, e);
  endtask

  initial begin
    int acc;
    bit first;
    wif.wr_valid = 1'b0;
    wif.wr_sof   = 1'b0;
    wif.wr_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_color", color, 16'h0000);
    chk("rst_ready", wif.wr_ready, 1'b0);
    chk("rst_addr", wif.wr_addr, 15'd0);
    chk("rst_fs", frame_start, 1'b0);
    resetn = 1'b1;
    chk("ready_first", wif.wr_ready, 1'b0);
    tick();
    chk("ready_after", wif.wr_ready, 1'b1);
    repeat (4) tick();
    chk("idle_color", color, 16'h0000);
    chk("idle_fs", frame_start, 1'b0);
    chk("idle_addr", wif.wr_addr, 15'd0);

    // Fill the whole frame with random bytes and idle gaps.
    acc = 0;
    first = 1'b1;
    while (acc < 20480) begin
      if ($urandom_range(3) != 0) begin
        if (acc == 20479) chk("addr_last", wif.wr_addr, 15'd20479);
        wr_cycle(1'b1, first, 8'($urandom));
        first = 1'b0;
        acc++;
      end else begin
        wr_cycle(1'b0, 1'($urandom), 8'($urandom));
      end
    end
    chk("addr_wrap", wif.wr_addr, 15'd0);

    request(0, 0, 1'b1, 2);
    request(127, 159, 1'b1, 2);
    for (int i = 0; i < 300; i++)
      request($urandom_range(127), $urandom_range(159), 1'b1,
              $urandom_range(6));

    wr_cycle(1'b1, 1'b1, 8'hE0);
    wr_cycle(1'b1, 1'b0, 8'h1C);
    request(0, 0, 1'b1, 3);
    chk("dir_e0", color, 16'hF800);
    request(1, 0, 1'b1, 3);
    chk("dir_1c", color, 16'h07E0);

    request(0, 5, 1'b0, 1);
    chk("bar0", color, 16'hFFFF);
    request(16, 5, 1'b0, 1);
    chk("bar1", color, 16'hFFE0);
    request(80, 5, 1'b0, 1);
    chk("bar5", color, 16'hF800);
    request(127, 5, 1'b0, 1);
    chk("bar7", color, 16'h0000);
    request(3, 170, 1'b1, 1);
    chk("oor", color, 16'h0000);

    // Same-cycle write/read of address 5 returns the old byte.
    wr_cycle(1'b1, 1'b1, 8'h11);
    for (int i = 1; i < 5; i++) wr_cycle(1'b1, 1'b0, 8'($urandom));
    wr_cycle(1'b1, 1'b0, 8'hFF);
    wr_cycle(1'b1, 1'b1, 8'h22);
    for (int i = 1; i < 5; i++) wr_cycle(1'b1, 1'b0, 8'($urandom));
    chk("coll_addr", wif.wr_addr, 15'd5);
    x = 7'd5;
    y = 8'd0;
    fb_enable = 1'b1;
    next_pixel = 1'b1;
    wr_cycle(1'b1, 1'b0, 8'h03);
    next_pixel = 1'b0;
    tick();
    chk("coll_old", color, 16'hFFFF);
    request(5, 0, 1'b1, 2);
    chk("coll_new", color, 16'h001F);

    wr_cycle(1'b1, 1'b1, 8'($urandom));
    for (int i = 1; i < 7; i++) wr_cycle(1'b1, 1'b0, 8'($urandom));
    wr_cycle(1'b0, 1'b1, 8'h55);
    wr_cycle(1'b0, 1'b0, 8'h66);
    chk("drop_addr", wif.wr_addr, 15'd7);
    wr_cycle(1'b1, 1'b0, 8'h9A);
    chk("drop_next", wif.wr_addr, 15'd8);
    request(7, 0, 1'b1, 1);
    chk("drop_data", color, rgb(8'h9A));

    // Mixed random traffic.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(2) != 0) begin
        for (int k = 0; k < int'($urandom_range(1, 20)); k++)
          wr_cycle(1'($urandom_range(3) != 0), ($urandom_range(15) == 0),
                   8'($urandom));
        chk("rnd_addr", wif.wr_addr, 32'(mdl_addr));
      end else begin
        request($urandom_range(127), $urandom_range(175), 1'($urandom),
                $urandom_range(10));
      end
    end

    // Asynchronous reset mid-run keeps RAM but clears state.
    #3;
    resetn = 1'b0;
    #1;
    chk("mrst_color", color, 16'h0000);
    chk("mrst_addr", wif.wr_addr, 15'd0);
    chk("mrst_ready", wif.wr_ready, 1'b0);
    mdl_addr = 0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    chk("mrst_ready1", wif.wr_ready, 1'b1);
    for (int i = 0; i < 20; i++)
      request($urandom_range(127), $urandom_range(159), 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
